// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a valid/ready word input and a
// valid-qualified serial output. Bit order (MSB or LSB first) is chosen per
// word at accept time. The downstream can pause the stream with hold.
//
// Handshake: a word transfers on a rising clk edge where din_valid and
// din_ready are both 1. din_valid may be raised at any time and must stay
// high, with din stable, until that transfer; din_ready never depends on
// din_valid. sout/last are meaningful only when sout_valid is 1. Each valid
// cycle consumes one bit; hold suppresses sout_valid and consumes nothing.
//
// busy mirrors the FSM state (1 = SHIFT), so it also serves as the state
// probe for external checkers.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             dir,
  input  logic             hold,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic             accept;
  logic             advance;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        accept    = din_valid;
        if (din_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        sout       = dir_q ? shreg[0] : shreg[WIDTH-1];
        sout_valid = !hold;
        last       = !hold && cnt_zero;
        din_ready  = !hold && cnt_zero;
        accept     = !hold && cnt_zero && din_valid;
        advance    = !hold && !cnt_zero;
        // Final bit going out with no follow-on word: drop back to IDLE.
        if (!hold && cnt_zero && !din_valid) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and latched bit order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (accept) begin
      shreg <= din;
      cnt   <= CNT_LOAD;
      dir_q <= dir;
    end else if (advance) begin
      if (dir_q) begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end else begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4). Stimulus tasks push the
// hand-computed serial bit sequence ({last, bit}) into exp_q; a monitor pops
// and compares on every sout_valid cycle. Timing checks run inline.
module tb_piso_serializer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dir;
  logic             hold;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  logic [1:0] exp_q[$];
  int checks;
  int errors;
  int vcnt;
  int lcnt;
  int cyc;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dir        (dir),
    .hold       (hold),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last),
    .busy       (busy)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Push a 4-bit sequence in emission order (seq[3] first), last on final bit
  task automatic push_seq(input logic [3:0] seq);
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back({(i == 0), seq[i]});
    end
  endtask

  // Offer a word and wait for its transfer; returns 1 time unit after accept edge
  task automatic send(input logic [3:0] w, input logic d, input bit keep_valid);
    int n;
    din       = w;
    dir       = d;
    din_valid = 1'b1;
    n = 0;
    while (din_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep_valid) din_valid = 1'b0;
  endtask

  // Expect n contiguous valid bits with last on the n-th, then idle
  task automatic expect_run(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_valid"}, int'(sout_valid), 1);
      chk({name, "_last"}, int'(last), (i == n - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk({name, "_idle_busy"}, int'(busy), 0);
    chk({name, "_idle_ready"}, int'(din_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_sout"}, int'(sout), 0);
    chk({name, "_valid"}, int'(sout_valid), 0);
    chk({name, "_last"}, int'(last), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_ready"}, int'(din_ready), 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst === 1'b1 && sout_valid === 1'b1) begin
      vcnt++;
      if (last === 1'b1) lcnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_bit got sout=%0b last=%0b expected none", sout, last);
      end else begin
        e = exp_q.pop_front();
        if ({last, sout} !== e) begin
          errors++;
          $display("FAIL sb_bit got last=%0b sout=%0b expected last=%0b sout=%0b",
                   last, sout, e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int v0;
    int l0;
    int c0;
    checks    = 0;
    errors    = 0;
    vcnt      = 0;
    lcnt      = 0;
    cyc       = 0;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    dir       = 1'b0;
    hold      = 1'b0;

    // Reset state before any clock edge
    #2;
    chk_reset_outputs("reset_initial");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // MSB first, 1011 -> 1,0,1,1 (first accept right after reset release)
    push_seq(4'b1011);
    send(4'b1011, 1'b0, 1'b0);
    expect_run("msb", 4);

    // LSB first, 1011 -> 1,1,0,1; din/dir/din_valid wiggle mid-word is ignored
    push_seq(4'b1101);
    send(4'b1011, 1'b1, 1'b0);
    @(posedge clk); #1;
    din = 4'b0000; dir = 1'b0; din_valid = 1'b1;
    chk("lsb_busy_not_ready", int'(din_ready), 0);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("lsb_idle_busy", int'(busy), 0);

    // hold in IDLE has no effect
    hold = 1'b1;
    #1;
    chk("idle_hold_ready", int'(din_ready), 1);
    chk("idle_hold_valid", int'(sout_valid), 0);
    @(posedge clk); #1;
    hold = 1'b0;

    // Back-to-back 1100 then 0011, MSB first, din_valid held
    v0 = vcnt; l0 = lcnt;
    push_seq(4'b1100);
    push_seq(4'b0011);
    send(4'b1100, 1'b0, 1'b1);
    c0 = cyc;
    send(4'b0011, 1'b0, 1'b0);
    chk("b2b_second_accept_cycle", cyc - c0, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_tail_valid", int'(sout_valid), 1);
    end
    @(negedge clk);
    chk("b2b_idle_busy", int'(busy), 0);
    chk("b2b_valid_count", vcnt - v0, 8);
    chk("b2b_last_count", lcnt - l0, 2);

    // Hold for 2 cycles after the 2nd bit of 1011
    push_seq(4'b1011);
    send(4'b1011, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold = 1'b1;
    @(negedge clk);
    chk("hold_valid_low1", int'(sout_valid), 0);
    chk("hold_busy1", int'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_valid_low2", int'(sout_valid), 0);
    chk("hold_ready_low", int'(din_ready), 0);
    chk("hold_last_low", int'(last), 0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    chk("hold_bit3_valid", int'(sout_valid), 1);
    chk("hold_bit3_last", int'(last), 0);
    @(negedge clk);
    chk("hold_bit4_last", int'(last), 1);
    @(negedge clk);
    chk("hold_idle_busy", int'(busy), 0);

    // Mid-word reset after 2nd bit of 1111; remaining bits must never appear
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    send(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset_midword");
    @(posedge clk); #1;
    chk_reset_outputs("reset_held");
    rst = 1'b1;
    #1;
    chk("post_reset_valid", int'(sout_valid), 0);
    push_seq(4'b0101);
    send(4'b0101, 1'b0, 1'b0);
    expect_run("post_reset", 4);

    chk("sb_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, parallel word width; legal range 2..32.
REQ-002 SHALL provide clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 SHALL provide din  input  WIDTH  parallel word to serialize.
REQ-005 SHALL provide din_valid  input  1  upstream offers din.
REQ-006 SHALL provide din_ready  output  1  block accepts din this cycle.
REQ-007 SHALL provide dir  input  1  bit order: 0 = MSB first (left shift), 1 = LSB first (right shift).
REQ-008 SHALL provide hold  input  1  downstream pause; freezes serialization.
REQ-009 SHALL provide sout  output  1  serial data bit.
REQ-010 SHALL provide sout_valid  output  1  sout carries a valid bit this cycle.
REQ-011 SHALL provide last  output  1  current valid bit is final bit of word.
REQ-012 SHALL provide busy  output  1  word in flight (state SHIFT).

Function
REQ-013 SHALL implement two states: IDLE, SHIFT.
REQ-014 SHALL accept a word on a rising edge where din_valid=1 and din_ready=1 (accept = transfer).
REQ-015 On accept, SHALL load din into WIDTH-bit shift register, latch dir into dir_q, load bit counter with WIDTH-1, enter SHIFT.
REQ-016 SHALL use a bit counter of width clog2(WIDTH), counting down; no wrap below 0.
REQ-017 SHALL drive sout = shreg[WIDTH-1] when dir_q=0, shreg[0] when dir_q=1; sout=0 in IDLE.
REQ-018 SHALL drive sout_valid = 1 iff state=SHIFT and hold=0.
REQ-019 SHALL drive last = 1 iff state=SHIFT, counter=0, hold=0.
REQ-020 SHALL drive busy = 1 iff state=SHIFT.
REQ-021 In SHIFT with hold=0 and counter>0, each edge SHALL shift toward the output end (left for dir_q=0, right for dir_q=1), fill vacated bit with 0, decrement counter.
REQ-022 In SHIFT with hold=1, SHALL freeze shreg, counter, dir_q, state; no bit consumed.
REQ-023 SHALL drive din_ready = 1 in IDLE, or in SHIFT when counter=0 and hold=0; otherwise 0.
REQ-024 At counter=0, hold=0: if din_valid=1, SHALL load next word and stay in SHIFT (zero-bubble back-to-back); else SHALL return to IDLE.
REQ-025 Latency: first bit of a word SHALL appear on sout in the cycle immediately after the accept edge; a word SHALL occupy exactly WIDTH sout_valid cycles plus hold cycles.
REQ-026 SHALL ignore din and dir changes while not accepting; dir affects only the next accepted word.
REQ-027 din_valid=1 while din_ready=0 SHALL be ignored without loss of the in-flight word; upstream holds din stable until accepted.
REQ-028 hold asserted in IDLE SHALL have no effect; din_ready remains 1.

Reset
REQ-029 On rst=0, SHALL asynchronously force state=IDLE, shreg=0, counter=0, dir_q=0.
REQ-030 During and after reset: sout=0, sout_valid=0, last=0, busy=0, din_ready=1.
REQ-031 Reset mid-word SHALL abort the word; remaining bits are discarded, not emitted after release.
REQ-032 First accept SHALL be possible on the first rising edge after rst returns high.

Verification (WIDTH=4)
REQ-033 Reset: rst=0 at any time -> sout=0, sout_valid=0, last=0, busy=0, din_ready=1 without waiting for clk.
REQ-034 MSB-first: din=4'b1011, dir=0, one-cycle valid -> sout 1,0,1,1 on 4 consecutive sout_valid cycles, last on 4th, then IDLE.
REQ-035 LSB-first: din=4'b1011, dir=1 -> sout 1,1,0,1, last on 4th.
REQ-036 Back-to-back: 4'b1100 then 4'b0011, dir=0, din_valid held -> 8 contiguous valid bits 1,1,0,0,0,0,1,1, second accept on 4th bit edge, last on bits 4 and 8.
REQ-037 Hold: 4'b1011 dir=0, hold=1 for 2 cycles after 2nd bit -> sout_valid low 2 cycles, sequence 1,0,1,1 intact, last 2 cycles later than REQ-034.
REQ-038 Mid-word reset: rst=0 after 2nd bit of 4'b1111 -> outputs cleared immediately; next word 4'b0101 dir=0 -> exactly 0,1,0,1.
